// File: rtl/rom_download_packer.sv
// rtl/rom_download_packer.sv - packs the ioctl ROM download byte stream into 16-bit sdram word writes
//
// Purpose:
//   Pairs even/odd download bytes into 16-bit words and rebases the address by BASE_ADDR.
//   Buffers the words in a small FIFO and drains them through the sdram toggle req/ack port.
//   Flags rom_loaded once the download has ended and every word has been acknowledged.
// Ports:
//   clk_sys, res_n_i                  clock, asynchronous active-low reset
//   ioctl_downl/wr/addr/dout          data_io download byte stream (wr rising edge = byte)
//   port_req/ack                      sdram toggle handshake (ack == req -> write done)
//   port_a/ds/d/we                    sdram word address, byte enables {hi,lo}, data, write enable
//   rom_loaded                        download complete and drained
//   overflow                          sticky: a word was dropped because the FIFO was full
module rom_download_packer #(
  parameter logic [24:0] BASE_ADDR  = 25'h0000000,
  parameter logic [24:0] LIMIT_ADDR = 25'h1FFFFFF,
  parameter int          FIFO_AW    = 3
) (
  input  logic        clk_sys,
  input  logic        res_n_i,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port_req,
  input  logic        port_ack,
  output logic [22:0] port_a,
  output logic [1:0]  port_ds,
  output logic [15:0] port_d,
  output logic        port_we,
  output logic        rom_loaded,
  output logic        overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int FW    = 23 + 2 + 16;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             state_q, state_d;
  logic               ioctl_wr_q, downl_q;
  logic               pend_q, pend_d;
  logic [7:0]         hold_q, hold_d;
  logic [22:0]        pend_a_q, pend_a_d;
  logic               stage_v_q, stage_v_d;
  logic [22:0]        stage_a_q, stage_a_d;
  logic [7:0]         stage_b_q, stage_b_d;
  logic [FIFO_AW:0]   wp_q, wp_d, rp_q, rp_d;
  logic [FW-1:0]      mem_q [DEPTH];
  logic               port_req_q, port_req_d;
  logic [22:0]        port_a_q, port_a_d;
  logic [1:0]         port_ds_q, port_ds_d;
  logic [15:0]        port_d_q, port_d_d;
  logic               port_we_q, port_we_d;
  logic               rom_loaded_q, rom_loaded_d;
  logic               overflow_q, overflow_d;
  logic               loading_q, loading_d;

  // Borrow bits of the two subtractions give the range check without constant compares.
  logic [25:0] below, above;
  logic [23:0] rel;
  logic [22:0] wa;
  logic        in_range, wr_evt, dl_rise;
  logic        fifo_empty, fifo_full, pop, push_v, do_push;
  logic [FW-1:0] push_w, head;
  logic        unused_bits;

  assign below       = {1'b0, ioctl_addr} - {1'b0, BASE_ADDR};
  assign above       = {1'b0, LIMIT_ADDR} - {1'b0, ioctl_addr};
  assign rel         = below[23:0];
  assign wa          = rel[23:1];
  assign in_range    = ~below[25] & ~above[25];
  assign unused_bits = ^{below[24], above[24:0]};
  assign wr_evt      = ioctl_wr & ~ioctl_wr_q & ioctl_downl & in_range;
  assign dl_rise     = ioctl_downl & ~downl_q;
  assign fifo_empty  = (wp_q == rp_q);
  assign fifo_full   = (wp_q[FIFO_AW] != rp_q[FIFO_AW]) &&
                       (wp_q[FIFO_AW-1:0] == rp_q[FIFO_AW-1:0]);
  assign head        = mem_q[rp_q[FIFO_AW-1:0]];
  assign do_push     = push_v & (~fifo_full | pop);

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    hold_d       = hold_q;
    pend_a_d     = pend_a_q;
    stage_v_d    = stage_v_q;
    stage_a_d    = stage_a_q;
    stage_b_d    = stage_b_q;
    port_req_d   = port_req_q;
    port_a_d     = port_a_q;
    port_ds_d    = port_ds_q;
    port_d_d     = port_d_q;
    rom_loaded_d = rom_loaded_q;
    overflow_d   = overflow_q;
    loading_d    = loading_q;
    push_v       = 1'b0;
    push_w       = '0;
    pop          = 1'b0;

    // Staged odd byte goes out the cycle after its event; the end-of-download
    // flush waits for it so only one word is pushed per cycle.
    if (stage_v_q) begin
      push_v    = 1'b1;
      push_w    = {stage_a_q, 2'b10, stage_b_q, stage_b_q};
      stage_v_d = 1'b0;
    end else if (!ioctl_downl && pend_q) begin
      push_v = 1'b1;
      push_w = {pend_a_q, 2'b01, hold_q, hold_q};
      pend_d = 1'b0;
    end

    if (wr_evt) begin
      if (!rel[0]) begin
        if (pend_q) begin
          push_v = 1'b1;
          push_w = {pend_a_q, 2'b01, hold_q, hold_q};
        end
        hold_d   = ioctl_dout;
        pend_a_d = wa;
        pend_d   = 1'b1;
      end else if (pend_q && (wa == pend_a_q)) begin
        push_v = 1'b1;
        push_w = {wa, 2'b11, ioctl_dout, hold_q};
        pend_d = 1'b0;
      end else begin
        if (pend_q) begin
          push_v = 1'b1;
          push_w = {pend_a_q, 2'b01, hold_q, hold_q};
        end
        pend_d    = 1'b0;
        stage_v_d = 1'b1;
        stage_a_d = wa;
        stage_b_d = ioctl_dout;
      end
    end

    if (state_q == S_IDLE) begin
      if (!fifo_empty) begin
        pop        = 1'b1;
        port_a_d   = head[40:18];
        port_ds_d  = head[17:16];
        port_d_d   = head[15:0];
        port_req_d = ~port_req_q;
        state_d    = S_BUSY;
      end
    end else if (port_ack == port_req_q) begin
      state_d = S_IDLE;
    end

    if (push_v && fifo_full && !pop) overflow_d = 1'b1;

    if (loading_q && !ioctl_downl && fifo_empty && !pend_q && !stage_v_q &&
        (state_q == S_IDLE)) begin
      rom_loaded_d = 1'b1;
      loading_d    = 1'b0;
    end

    if (dl_rise) begin
      rom_loaded_d = 1'b0;
      overflow_d   = 1'b0;
      loading_d    = 1'b1;
    end
  end

  assign wp_d      = wp_q + {{FIFO_AW{1'b0}}, do_push};
  assign rp_d      = rp_q + {{FIFO_AW{1'b0}}, pop};
  assign port_we_d = ioctl_downl | ~fifo_empty | (state_q == S_BUSY);

  always_ff @(posedge clk_sys or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q      <= S_IDLE;
      ioctl_wr_q   <= 1'b0;
      downl_q      <= 1'b0;
      pend_q       <= 1'b0;
      hold_q       <= '0;
      pend_a_q     <= '0;
      stage_v_q    <= 1'b0;
      stage_a_q    <= '0;
      stage_b_q    <= '0;
      wp_q         <= '0;
      rp_q         <= '0;
      port_req_q   <= 1'b0;
      port_a_q     <= '0;
      port_ds_q    <= '0;
      port_d_q     <= '0;
      port_we_q    <= 1'b0;
      rom_loaded_q <= 1'b0;
      overflow_q   <= 1'b0;
      loading_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ioctl_wr_q   <= ioctl_wr;
      downl_q      <= ioctl_downl;
      pend_q       <= pend_d;
      hold_q       <= hold_d;
      pend_a_q     <= pend_a_d;
      stage_v_q    <= stage_v_d;
      stage_a_q    <= stage_a_d;
      stage_b_q    <= stage_b_d;
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      port_req_q   <= port_req_d;
      port_a_q     <= port_a_d;
      port_ds_q    <= port_ds_d;
      port_d_q     <= port_d_d;
      port_we_q    <= port_we_d;
      rom_loaded_q <= rom_loaded_d;
      overflow_q   <= overflow_d;
      loading_q    <= loading_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wp_q[FIFO_AW-1:0]] <= push_w;
  end

  assign port_req   = port_req_q;
  assign port_a     = port_a_q;
  assign port_ds    = port_ds_q;
  assign port_d     = port_d_q;
  assign port_we    = port_we_q;
  assign rom_loaded = rom_loaded_q;
  assign overflow   = overflow_q;

endmodule
